// File: rtl/buzzer_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the buzzer/melody blocks: playback states, the
// tick-period helper and note half-periods at a 100 MHz system clock.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Clock cycles per duration tick.
  function automatic int tick_cycles(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Half-periods in 100 MHz cycles, used by the melody sequencer.
  localparam int NOTE_C4   = 191110;
  localparam int NOTE_D4   = 170262;
  localparam int NOTE_E4   = 151685;
  localparam int NOTE_F4   = 143172;
  localparam int NOTE_G4   = 127551;
  localparam int NOTE_A4   = 113636;
  localparam int NOTE_B4   = 101239;
  localparam int NOTE_C5   = 95556;
  localparam int NOTE_REST = 0;

endpackage

// File: rtl/note_player_tick_gen.sv
`timescale 1ns/1ps
// Duration prescaler: emits a one-cycle tick every TICK_CYC enabled cycles.
// clr restarts the phase so a freshly accepted note gets whole ticks.
module tick_gen #(
  parameter int TICK_CYC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PRE_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic [PRE_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == PRE_W'(TICK_CYC - 1));
  assign tick   = en && w_wrap;

  // Prescaler counts 0..TICK_CYC-1 while enabled, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/note_player.sv
`timescale 1ns/1ps
// Note playback: accepts {half-period, duration} per handshake, plays a
// square wave for the duration, holds a silent gap, then pulses note_done.
module note_player
  import buzzer_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int GAP_MS  = 20,
  parameter int HALF_W  = 20,
  parameter int DUR_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [HALF_W-1:0] note_half,
  input  logic [DUR_W-1:0]  note_dur,
  input  logic              stop,
  output logic              buzzer,
  output logic              busy,
  output logic              note_done
);

  localparam int TICK_CYC = tick_cycles(CLK_HZ, TICK_HZ);
  // The tick counter also times the gap, so it must hold GAP_MS-1 as well.
  localparam int GAP_W    = $clog2(GAP_MS + 1);
  localparam int CNT_W    = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  if (CLK_HZ % TICK_HZ != 0) begin : g_bad_tick
    $error("note_player: CLK_HZ must be an integer multiple of TICK_HZ");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [HALF_W-1:0] r_half;
  logic [HALF_W-1:0] r_half_cnt;
  logic [DUR_W-1:0]  r_dur;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic              r_buzzer;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_accept;
  logic              w_tick;
  logic              w_clr;
  logic              w_toggle;
  logic              w_play_end;
  logic              w_gap_end;

  assign note_ready = (r_state == IDLE) && !stop && !reset;
  assign w_accept   = note_valid && note_ready;
  assign w_clr      = stop || w_accept;

  assign w_toggle   = (r_state == PLAY) && (r_half != '0) &&
                      (r_half_cnt == r_half - HALF_W'(1));
  assign w_play_end = (r_state == PLAY) && w_tick &&
                      (r_tick_cnt == CNT_W'(r_dur - DUR_W'(1)));
  assign w_gap_end  = (r_state == GAP) && w_tick &&
                      (r_tick_cnt == CNT_W'(GAP_MS - 1));

  assign buzzer    = r_buzzer;
  assign busy      = (r_state != IDLE);
  assign note_done = r_done;

  tick_gen #(
    .TICK_CYC (TICK_CYC)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (r_state != IDLE),
    .tick  (w_tick)
  );

  // Next state and completion pulse; stop overrides accept and completion.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (stop) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (note_dur == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = PLAY;
            end
          end
        end
        PLAY: begin
          if (w_play_end) begin
            if (GAP_MS == 0) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = GAP;
            end
          end
        end
        GAP: begin
          if (w_gap_end) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register and registered completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Note parameters are captured on accept so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_half <= '0;
      r_dur  <= '0;
    end else if (w_accept) begin
      r_half <= note_half;
      r_dur  <= note_dur;
    end
  end

  // Half-period counter wraps at half-1; frozen for rests.
  always_ff @(posedge clk) begin
    if (reset || w_clr || (r_state != PLAY)) begin
      r_half_cnt <= '0;
    end else if (r_half != '0) begin
      r_half_cnt <= w_toggle ? '0 : r_half_cnt + HALF_W'(1);
    end
  end

  // Tick counter times the note and then the gap; restarts at each phase.
  always_ff @(posedge clk) begin
    if (reset || w_clr || w_play_end || w_gap_end) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  // Square-wave output, forced low outside PLAY and on leaving PLAY.
  always_ff @(posedge clk) begin
    if (reset || w_clr || (r_state != PLAY) || w_play_end) begin
      r_buzzer <= 1'b0;
    end else if (w_toggle) begin
      r_buzzer <= ~r_buzzer;
    end
  end

endmodule
